rpn_ctrl: RTL and testbench

Command sequencer that turns a stream of reverse-Polish commands into push/pop traffic on the 8-bit, 32-entry LIFO stack, and performs arithmetic on popped operands. It sits directly upstream of the stack, driving its `push`/`in`/`pop` inputs. It also consumes the stack's `out`/`is_empty` and writes results back as a push. It tracks stack occupancy itself, because the stack has no full flag, and reports underflow, overflow and illegal-opcode errors.

---
 rtl/rpn_pkg.sv | 31 +++
 rtl/rpn_if.sv | 23 ++
 rtl/rpn_alu.sv | 30 +++
 rtl/rpn_ctrl.sv | 133 +++++++++++++
 tb/tb_rpn_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rpn_pkg.sv
// rpn_pkg: shared types and constants for the RPN command sequencer.
// Opcode 111 is MUL only when RPN_MUL_EN is defined; otherwise it is rejected as illegal.
package rpn_pkg;

    // Command opcodes as presented on cmd_op.
    typedef enum logic [2:0] {
        OpLit  = 3'b000,
        OpAdd  = 3'b001,
        OpSub  = 3'b010,
        OpAnd  = 3'b011,
        OpOr   = 3'b100,
        OpXor  = 3'b101,
        OpDrop = 3'b110,
        OpMul  = 3'b111
    } op_e;

    // Sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StPopB,
        StPopA,
        StExec,
        StPush,
        StSet1,
        StSet2
    } state_e;

    // Cycles the stack needs after a push before it can take another pop or push.
    localparam int unsigned RPN_SETTLE = 2;

endpackage

// File: rtl/rpn_if.sv
// rpn_if: command/result handshake between a command source and rpn_ctrl.
interface rpn_if
    import rpn_pkg::*;
#(
    parameter int unsigned W = 8
) ();
    logic         cmd_valid;
    logic         cmd_ready;
    op_e          cmd_op;
    logic [W-1:0] cmd_data;
    logic [W-1:0] result;
    logic         result_valid;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, result, result_valid
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, result, result_valid
    );
endinterface

// File: rtl/rpn_alu.sv
// rpn_alu: combinational binary operator y = a op b, results wrap mod 2^W.
// The multiplier exists only when RPN_MUL_EN is defined.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  op_e          op,
    output logic [W-1:0] y
);

    // Select the operation; non-arithmetic opcodes yield zero.
    always_comb begin
        y = '0;
        case (op)
            OpAdd: y = a + b;
            OpSub: y = a - b;
            OpAnd: y = a & b;
            OpOr:  y = a | b;
            OpXor: y = a ^ b;
`ifdef RPN_MUL_EN
            OpMul: y = a * b; // low W bits of the product
`endif
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rpn_ctrl.sv
// rpn_ctrl: turns RPN commands into push/pop traffic on a LIFO stack with no full flag,
// tracks occupancy locally and raises sticky underflow/overflow/illegal errors.
// Build option: RPN_MUL_EN enables opcode 111 (MUL); without it MUL sets err_illegal.
module rpn_ctrl
    import rpn_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 32
) (
    input  logic                         m_clock,
    input  logic                         p_reset,
    rpn_if.slave                         bus,
    input  logic                         err_clr,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         err_underflow,
    output logic                         err_overflow,
    output logic                         err_illegal,
    output logic                         stk_push,
    output logic [W-1:0]                 stk_in,
    output logic                         stk_pop,
    input  logic [W-1:0]                 stk_out,
    input  logic                         stk_is_empty
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DepthFull = DW'(DEPTH);

    state_e       state;
    op_e          op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] alu_y;

    rpn_alu #(
        .W (W)
    ) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    // Handshake and stack strobes come straight off the state register.
    assign bus.cmd_ready = (state == StIdle);
    assign stk_pop       = (state == StPopB) || (state == StPopA);
    assign stk_push      = (state == StPush);

    // Sequencer: accepts or rejects commands, walks pop/exec/push, keeps depth and errors.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state            <= StIdle;
            op_q             <= OpLit;
            a_q              <= '0;
            b_q              <= '0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            stk_in           <= '0;
            depth            <= '0;
            err_underflow    <= 1'b0;
            err_overflow     <= 1'b0;
            err_illegal      <= 1'b0;
        end else begin
            bus.result_valid <= 1'b0;
            // Clear first so a same-cycle set (assigned later) wins.
            if (err_clr) begin
                err_underflow <= 1'b0;
                err_overflow  <= 1'b0;
                err_illegal   <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        op_q <= bus.cmd_op;
                        case (bus.cmd_op)
                            OpLit: begin
                                if (depth == DepthFull) begin
                                    err_overflow <= 1'b1;
                                end else begin
                                    stk_in <= bus.cmd_data;
                                    state  <= StPush;
                                end
                            end
                            OpDrop: begin
                                if (depth == '0) err_underflow <= 1'b1;
                                else             state         <= StPopB;
                            end
`ifndef RPN_MUL_EN
                            OpMul: err_illegal <= 1'b1;
`endif
                            default: begin
                                if (depth < DW'(2)) err_underflow <= 1'b1;
                                else                state         <= StPopB;
                            end
                        endcase
                    end
                end
                StPopB: begin
                    b_q   <= stk_out;
                    depth <= depth - 1'b1;
                    state <= (op_q == OpDrop) ? StIdle : StPopA;
                end
                StPopA: begin
                    a_q   <= stk_out;
                    depth <= depth - 1'b1;
                    state <= StExec;
                end
                StExec: begin
                    bus.result       <= alu_y;
                    stk_in           <= alu_y;
                    bus.result_valid <= 1'b1;
                    state            <= StPush;
                end
                StPush: begin
                    depth <= depth + 1'b1;
                    state <= StSet1;
                end
                StSet1:  state <= StSet2;
                StSet2:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Warn when our occupancy disagrees with the stack's own empty flag.
    always_ff @(posedge m_clock) begin
        if (p_reset && (state == StIdle) && (stk_is_empty != (depth == '0))) begin
            $warning("rpn_ctrl: stk_is_empty=%0b disagrees with depth=%0d", stk_is_empty, depth);
        end
    end
`endif

endmodule

// File: tb/tb_rpn_ctrl.sv
// tb_rpn_ctrl: scoreboard bench for rpn_ctrl with a behavioural two-cycle-commit LIFO.
module tb_rpn_ctrl;
    import rpn_pkg::*;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 32;
`ifdef RPN_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    logic       m_clock = 1'b0;
    logic       p_reset = 1'b0;
    logic       err_clr = 1'b0;
    logic [5:0] depth;
    logic       err_underflow, err_overflow, err_illegal;
    logic       stk_push, stk_pop, stk_is_empty;
    logic [7:0] stk_in, stk_out;

    rpn_if #(.W(W)) bus ();

    rpn_ctrl #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .m_clock       (m_clock),
        .p_reset       (p_reset),
        .bus           (bus),
        .err_clr       (err_clr),
        .depth         (depth),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow),
        .err_illegal   (err_illegal),
        .stk_push      (stk_push),
        .stk_in        (stk_in),
        .stk_pop       (stk_pop),
        .stk_out       (stk_out),
        .stk_is_empty  (stk_is_empty)
    );

    always #5 m_clock = ~m_clock;

    // Stack model: push registers the input, the next edge writes memory and bumps the pointer.
    logic [7:0] smem [DEPTH];
    logic [5:0] sp;
    logic [7:0] sin;
    logic       spend;
    always @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            sp    <= '0;
            sin   <= '0;
            spend <= 1'b0;
        end else begin
            spend <= stk_push;
            if (stk_push) sin <= stk_in;
            if (spend) begin
                smem[5'(sp)] <= sin;
                sp           <= sp + 6'd1;
            end else if (stk_pop) begin
                sp <= sp - 6'd1;
            end
        end
    end
    assign stk_out      = (sp == 6'd0) ? 8'h00 : smem[5'(sp - 6'd1)];
    assign stk_is_empty = (sp == 6'd0);

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Reference state: stack contents, expected results, expected error flags.
    logic [7:0] mstk [$];
    logic [7:0] exp_q [$];
    logic       exp_uf = 1'b0, exp_ov = 1'b0, exp_il = 1'b0;

    function automatic logic [7:0] ref_op(input op_e op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            OpAdd:   return a + b;
            OpSub:   return a - b;
            OpAnd:   return a & b;
            OpOr:    return a | b;
            OpXor:   return a ^ b;
            OpMul:   return p[7:0];
            default: return 8'h00;
        endcase
    endfunction

    // Monitor: result scoreboard, pulse width, push/pop spacing and strobe counts.
    int   push_cnt = 0, pop_cnt = 0, since_push = 100;
    logic prev_rv = 1'b0;
    always @(negedge m_clock) begin
        if (bus.result_valid) begin
            check("rv_width", 32'(prev_rv), 0);
            if (exp_q.size() == 0) check("rv_unexpected", 1, 0);
            else                   check("result", 32'(bus.result), 32'(exp_q.pop_front()));
        end
        if (stk_push || stk_pop) begin
            check("settle_gap", 32'(since_push >= RPN_SETTLE), 1);
            check("push_pop_excl", 32'(stk_push && stk_pop), 0);
        end
        if (stk_push)           since_push = 0;
        else if (since_push < 100) since_push++;
        push_cnt += int'(stk_push);
        pop_cnt  += int'(stk_pop);
        prev_rv   = bus.result_valid;
    end

    task automatic check_errs(input string tag);
        check({tag, "_uf"}, 32'(err_underflow), 32'(exp_uf));
        check({tag, "_ov"}, 32'(err_overflow), 32'(exp_ov));
        check({tag, "_il"}, 32'(err_illegal), 32'(exp_il));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, 32'(bus.cmd_ready), 1);
        check({tag, "_result"}, 32'(bus.result), 0);
        check({tag, "_rv"}, 32'(bus.result_valid), 0);
        check({tag, "_depth"}, 32'(depth), 0);
        check({tag, "_push"}, 32'(stk_push), 0);
        check({tag, "_pop"}, 32'(stk_pop), 0);
        check({tag, "_stk_in"}, 32'(stk_in), 0);
        check_errs(tag);
    endtask

    // Drive one command, update the reference model and check its effects.
    task automatic send(input op_e op, input logic [7:0] d);
        int         busy, exp_busy, exp_push, exp_pop, p0, q0;
        logic [7:0] a, b, y;
        exp_busy = 0; exp_push = 0; exp_pop = 0;
        case (op)
            OpLit: begin
                if (mstk.size() == DEPTH) exp_ov = 1'b1;
                else begin mstk.push_back(d); exp_push = 1; exp_busy = 3; end
            end
            OpDrop: begin
                if (mstk.size() < 1) exp_uf = 1'b1;
                else begin void'(mstk.pop_back()); exp_pop = 1; exp_busy = 1; end
            end
            default: begin
                if (op == OpMul && !MulEn) exp_il = 1'b1;
                else if (mstk.size() < 2) exp_uf = 1'b1;
                else begin
                    b = mstk.pop_back();
                    a = mstk.pop_back();
                    y = ref_op(op, a, b);
                    mstk.push_back(y);
                    exp_q.push_back(y);
                    exp_pop = 2; exp_push = 1; exp_busy = 6;
                end
            end
        endcase
        p0 = push_cnt;
        q0 = pop_cnt;
        @(negedge m_clock);
        check("ready_before", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        @(posedge m_clock);
        #1;
        bus.cmd_valid = 1'b0;
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge m_clock);
            if (bus.cmd_ready) break;
            busy++;
        end
        check("busy_cycles", 32'(busy), 32'(exp_busy));
        check("depth", 32'(depth), 32'(mstk.size()));
        check("push_count", 32'(push_cnt - p0), 32'(exp_push));
        check("pop_count", 32'(pop_cnt - q0), 32'(exp_pop));
        check("sb_drained", 32'(exp_q.size()), 0);
        if (mstk.size() > 0) check("stk_top", 32'(stk_out), 32'(mstk[$]));
        check_errs("errs");
    endtask

    task automatic clear_errs();
        @(negedge m_clock);
        err_clr = 1'b1;
        @(posedge m_clock);
        #1;
        err_clr = 1'b0;
        exp_uf = 1'b0; exp_ov = 1'b0; exp_il = 1'b0;
        check_errs("clr");
    endtask

    initial begin
        op_e ops [5];
        ops = '{OpAdd, OpSub, OpAnd, OpOr, OpXor};
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OpLit;
        bus.cmd_data  = 8'h00;
        repeat (2) @(negedge m_clock);
        check_reset("in_reset");
        p_reset = 1'b1;
        @(negedge m_clock);
        check_reset("after_reset");

        // Binary op on an empty stack.
        send(OpAdd, 8'h00);
        clear_errs();

        // 5 - 3 = 2, left on the stack.
        send(OpLit, 8'h05);
        send(OpLit, 8'h03);
        send(OpSub, 8'h00);
        send(OpDrop, 8'h00);

        // Wrapping add, then XOR to zero.
        send(OpLit, 8'hF0);
        send(OpLit, 8'h20);
        send(OpAdd, 8'h00);
        send(OpLit, 8'h10);
        send(OpXor, 8'h00);
        send(OpDrop, 8'h00);

        // Fill to capacity, overflow, then fold back down with random ops.
        for (int i = 0; i < DEPTH; i++) send(OpLit, 8'hAA);
        check("full_depth", 32'(depth), DEPTH);
        send(OpLit, 8'h55);
        clear_errs();
        for (int i = 0; i < DEPTH - 1; i++) send(ops[$urandom_range(0, 4)], 8'h00);
        send(OpSub, 8'h00);
        send(OpDrop, 8'h00);
        send(OpDrop, 8'h00);
        clear_errs();

        // MUL: product when enabled, illegal otherwise.
        send(OpLit, 8'h12);
        send(OpLit, 8'h10);
        send(OpMul, 8'h00);
        clear_errs();
        while (mstk.size() > 0) send(OpDrop, 8'h00);

        // Reset in the middle of an ADD, during POP_A.
        send(OpLit, 8'h07);
        send(OpLit, 8'h09);
        @(negedge m_clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OpAdd;
        @(posedge m_clock);
        #1;
        bus.cmd_valid = 1'b0;
        @(posedge m_clock);
        #1;
        check("in_pop_a", 32'(stk_pop), 1);
        p_reset = 1'b0;
        #1;
        check_reset("mid_reset");
        mstk.delete();
        exp_q.delete();
        @(negedge m_clock);
        p_reset = 1'b1;
        @(negedge m_clock);
        check("post_ready", 32'(bus.cmd_ready), 1);
        check("post_depth", 32'(depth), 0);
        check("post_empty", 32'(stk_is_empty), 1);
        send(OpLit, 8'h3C);
        send(OpDrop, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
